// File: rtl/i2s_receiver.sv
// I2S receiver: synchronizes SCLK/WS/SD into clk, deserializes standard-I2S
// left/right words and hands each {left, right} frame out over a valid/ready buffer.
`timescale 1ns/1ps

module i2s_receiver #(
    parameter int DWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SCLK,
    input  logic                  WS,
    input  logic                  SD,
    output logic [2*DWIDTH-1:0]   rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int            CW       = $clog2(DWIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DWIDTH);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DWIDTH + 1);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [1:0]          sclk_ff, ws_ff, sd_ff;
    logic                sclk_prev;
    logic                ws_prev;
    logic [DWIDTH-1:0]   shift_reg;
    logic [DWIDTH-1:0]   shift_next;
    logic [DWIDTH-1:0]   left_word;
    logic [CW-1:0]       bit_cnt, cnt_next, cnt_inc;
    logic                ws_s, sd_s;
    logic                bit_evt, ws_change;
    logic                latch_left, frame_done, len_err;

    assign ws_s       = ws_ff[1];
    assign sd_s       = sd_ff[1];
    assign bit_evt    = sclk_ff[1] & ~sclk_prev;
    assign ws_change  = bit_evt && (ws_s != ws_prev);
    assign shift_next = {shift_reg[DWIDTH-2:0], sd_s};
    // Counter holds at DWIDTH+1 so an overlong word can never wrap back to a legal length.
    assign cnt_inc    = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + 1'b1;

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = bit_cnt;
        latch_left = 1'b0;
        frame_done = 1'b0;
        len_err    = 1'b0;
        if (bit_evt) begin
            unique case (state)
                SYNC: begin
                    if (ws_change && !ws_s) begin
                        state_next = LEFT;
                        cnt_next   = '0;
                    end
                end
                LEFT: begin
                    cnt_next = cnt_inc;
                    if (ws_change) begin
                        cnt_next = '0;
                        if (cnt_inc == CNT_FULL) begin
                            latch_left = 1'b1;
                            state_next = RIGHT;
                        end else begin
                            len_err    = 1'b1;
                            state_next = SYNC;
                        end
                    end
                end
                RIGHT: begin
                    cnt_next = cnt_inc;
                    if (ws_change) begin
                        cnt_next = '0;
                        if (cnt_inc == CNT_FULL) begin
                            frame_done = 1'b1;
                            state_next = LEFT;
                        end else begin
                            len_err    = 1'b1;
                            state_next = SYNC;
                        end
                    end
                end
                default: state_next = SYNC;
            endcase
        end
    end

    // NOTE: all state, including the data registers, is cleared by the async reset so a
    // mid-frame reset leaves nothing partial behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SYNC;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_ff   <= '0;
            ws_ff     <= '0;
            sd_ff     <= '0;
            sclk_prev <= 1'b0;
            ws_prev   <= 1'b0;
            shift_reg <= '0;
            left_word <= '0;
            bit_cnt   <= '0;
        end else begin
            sclk_ff   <= {sclk_ff[0], SCLK};
            ws_ff     <= {ws_ff[0], WS};
            sd_ff     <= {sd_ff[0], SD};
            sclk_prev <= sclk_ff[1];
            bit_cnt   <= cnt_next;
            if (bit_evt) begin
                ws_prev   <= ws_s;
                shift_reg <= shift_next;
            end
            if (latch_left) begin
                left_word <= shift_next;
            end
        end
    end

    // Output buffer: a completing frame may replace the held one only when it is consumed
    // in the same cycle; otherwise the new frame is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= len_err;
            overrun   <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= {left_word, shift_next};
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: I2S stimulus at 8x clk/SCLK ratio with a
// scoreboard of expected {left, right} frames popped on each accepted output.
`timescale 1ns/1ps

module tb_i2s_receiver;

    localparam int DWIDTH = 8;

    logic                clk;
    logic                rst_n;
    logic                SCLK;
    logic                WS;
    logic                SD;
    logic [2*DWIDTH-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ready;
    logic                frame_err;
    logic                overrun;

    logic [2*DWIDTH-1:0] exp_q[$];
    int                  n_total = 0;
    int                  n_bad   = 0;
    int                  n_rx    = 0;
    int                  n_err   = 0;
    int                  n_ovr   = 0;

    i2s_receiver #(.DWIDTH(DWIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SCLK      (SCLK),
        .WS        (WS),
        .SD        (SD),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SCLK period = 8 clk cycles; data changes while SCLK is low, rises mid-period.
    // With pulse set, rx_ready is high only during the cycle the frame completes in the DUT.
    task automatic send_bit(input logic ws, input logic sd, input logic pulse);
        @(posedge clk); #3;
        SCLK = 1'b0;
        WS   = ws;
        SD   = sd;
        repeat (4) @(posedge clk);
        #3 SCLK = 1'b1;
        if (pulse) begin
            repeat (2) @(posedge clk);
            #2 rx_ready = 1'b1;
            @(posedge clk);
            #2 rx_ready = 1'b0;
        end else begin
            repeat (3) @(posedge clk);
        end
    endtask

    // Standard I2S: the word's LSB already carries the next word's WS value.
    task automatic send_word(input logic ws_this, input logic ws_next, input logic [7:0] data,
                             input int nbits, input logic pulse_last);
        for (int i = nbits - 1; i >= 0; i--) begin
            send_bit((i == 0) ? ws_next : ws_this, data[i], (i == 0) ? pulse_last : 1'b0);
        end
    endtask

    task automatic send_frame(input logic [7:0] l, input logic [7:0] r,
                              input logic push, input logic pulse_last);
        if (push) exp_q.push_back({l, r});
        send_word(1'b0, 1'b1, l, 8, 1'b0);
        send_word(1'b1, 1'b0, r, 8, pulse_last);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) n_err++;
            if (overrun)   n_ovr++;
            if (rx_valid && rx_ready) begin
                n_rx++;
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(exp_q.size()), 1);
                end else begin
                    check("rx_data", rx_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        SCLK     = 1'b0;
        WS       = 1'b1;
        SD       = 1'b0;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_data",   rx_data,   0);
        check("rst_rx_valid",  rx_valid,  0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun",   overrun,   0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Leading partial: right word only, closed by a WS fall
        send_word(1'b1, 1'b0, 8'h5A, 8, 1'b0);
        repeat (4) @(posedge clk);
        check("partial_dropped", n_rx, 0);

        // Three back-to-back frames with rx_ready held high
        send_frame(8'hA5, 8'h3C, 1'b1, 1'b0);
        send_frame(8'h12, 8'h34, 1'b1, 1'b0);
        send_frame(8'hFF, 8'h00, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        check("three_frames", n_rx, 3);
        check("no_err_clean", n_err, 0);
        check("no_ovr_clean", n_ovr, 0);

        // 7-bit left word, then resync and two good frames
        send_word(1'b0, 1'b1, 8'h55, 7, 1'b0);
        repeat (4) @(posedge clk);
        check("short_word_err", n_err, 1);
        check("short_no_frame", n_rx, 3);
        send_word(1'b1, 1'b0, 8'hC3, 8, 1'b0);
        send_frame(8'h69, 8'h96, 1'b1, 1'b0);
        send_frame(8'h0F, 8'hF0, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        check("resync_frames", n_rx, 5);
        check("err_single", n_err, 1);

        // Back-pressure: second frame is dropped with a single overrun
        @(posedge clk); #2 rx_ready = 1'b0;
        send_frame(8'h11, 8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 8'h22, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("hold_valid", rx_valid, 1);
        check("hold_data", rx_data, 32'h1111);
        check("overrun_once", n_ovr, 1);
        @(posedge clk); #2 rx_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("drain_valid", rx_valid, 0);
        check("drain_count", n_rx, 6);
        @(posedge clk); #2 rx_ready = 1'b0;

        // Accept in the exact completion cycle: swap without overrun
        send_frame(8'h33, 8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 8'h44, 1'b1, 1'b1);
        @(negedge clk);
        check("swap_valid", rx_valid, 1);
        check("swap_data", rx_data, 32'h4444);
        check("swap_no_ovr", n_ovr, 1);
        check("swap_popped", n_rx, 7);
        @(posedge clk); #2 rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        check("swap_drained", n_rx, 8);

        // Reset pulse in the middle of a right word
        send_word(1'b0, 1'b1, 8'h77, 8, 1'b0);
        for (int i = 7; i >= 4; i--) send_bit(1'b1, i[0], 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_rx_data",   rx_data,   0);
        check("mid_rst_rx_valid",  rx_valid,  0);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_overrun",   overrun,   0);
        #2 rst_n = 1'b1;
        for (int i = 3; i >= 0; i--) send_bit((i == 0) ? 1'b0 : 1'b1, i[0], 1'b0);
        repeat (4) @(posedge clk);
        check("post_rst_no_frame", n_rx, 8);
        send_frame(8'h5A, 8'hA5, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        check("post_rst_frame", n_rx, 9);
        check("queue_empty", 32'(exp_q.size()), 0);
        check("final_err", n_err, 1);
        check("final_ovr", n_ovr, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/i2s_receiver.md
I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 Parameter DWIDTH, default 8: bits per channel word.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SCLK  in  1  I2S bit clock, asynchronous to clk.
REQ-005 WS  in  1  I2S word select, asynchronous to clk; 0 = left, 1 = right.
REQ-006 SD  in  1  I2S serial data, MSB first, asynchronous to clk.
REQ-007 rx_data  out  2*DWIDTH  received frame {left, right}; left word in the upper DWIDTH bits.
REQ-008 rx_valid  out  1  rx_data holds an unconsumed frame.
REQ-009 rx_ready  in  1  consumer accepts the frame when rx_valid && rx_ready at a clk edge.
REQ-010 frame_err  out  1  one-cycle pulse: word length mismatch detected.
REQ-011 overrun  out  1  one-cycle pulse: completed frame dropped because the output buffer was full.

Function
REQ-012 SCLK, WS and SD shall each pass through a 2-flop synchronizer into clk; all decisions use synchronized values only.
REQ-013 A bit event shall be a rising edge of synchronized SCLK; the block samples synchronized WS and SD only at bit events.
REQ-014 Operating constraint: clk frequency >= 4x SCLK frequency; behaviour outside this constraint is unspecified.
REQ-015 A WS change shall be a bit event where sampled WS differs from WS at the previous bit event.
REQ-016 Timing is standard I2S: the SD bit at a WS-change event is the LSB of the outgoing word; the MSB of the new word is the next bit event.
REQ-017 FSM states: SYNC, LEFT, RIGHT; the reset state is SYNC.
REQ-018 SYNC: shift SD into a DWIDTH-bit shift register (oldest bit toward MSB) on every bit event; go to LEFT on a WS 1->0 change with the bit counter cleared; produce no output.
REQ-019 LEFT: shift SD and increment the bit counter per bit event; on a 0->1 change, include that bit and latch the left word, then go to RIGHT.
REQ-020 RIGHT: same as LEFT; on a 1->0 change, include that bit, form the frame {left, right}, then go to LEFT.
REQ-021 Word length check at every WS change in LEFT or RIGHT: the bit count including the change bit shall equal DWIDTH.
REQ-022 Length mismatch: pulse frame_err, discard the partial frame, go to SYNC; the mismatching change does not count as the SYNC exit edge.
REQ-023 The bit counter shall saturate at DWIDTH+1 and must not wrap.
REQ-024 Frame completion with rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data and set rx_valid=1.
REQ-025 Frame completion with rx_valid=1 and rx_ready=0: keep the old rx_data, drop the new frame, pulse overrun.
REQ-026 rx_valid && rx_ready with no completing frame: clear rx_valid next cycle.
REQ-027 rx_data shall be stable while rx_valid=1 and not yet accepted.
REQ-028 Latency: rx_valid rises no more than 4 clk cycles after the SCLK rising edge (at pins) that completes the frame.
REQ-029 rx_data is unchanged by frame_err; an already-buffered valid frame remains valid.

Reset
REQ-030 While rst_n=0: rx_data=0, rx_valid=0, frame_err=0, overrun=0, synchronizers=0, shift register and counter=0, FSM=SYNC.
REQ-031 Reset in mid-frame shall discard all partial data; after release, no output until a fresh WS 1->0 change is followed by a complete left/right pair.

Verification
REQ-032 DWIDTH=8, rx_ready=1, clk=8x SCLK: send 3 frames L=A5,R=3C / 12,34 / FF,00 -> rx_data=A53C, 1234, FF00 in order; one rx_valid pulse each; no errors.
REQ-033 Leading partial frame (right word only, then a WS fall) -> no rx_valid for the partial; first output is the following full frame.
REQ-034 Left word of 7 bits -> frame_err single pulse; no rx_valid for that frame; the next two correct frames after resync are received correctly.
REQ-035 rx_ready=0; frames 1111 then 2222 -> rx_data stays 1111 with rx_valid=1, overrun pulses once; raise rx_ready -> 1111 accepted, rx_valid clears.
REQ-036 rx_ready=1 in the exact cycle the next frame completes -> old frame accepted, new frame loaded, rx_valid stays 1, no overrun.
REQ-037 rst_n pulsed low for 3 ns mid right word -> all outputs 0 during reset; next valid output is the second WS-fall-delimited frame after release.
